// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Optional decode-stage branch support is selected by HAZARD_BRANCH_FWD_EN.
package hazard_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Execute-operand source select
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Producer match: register 0 is hard-wired zero and never matches
  function automatic logic reg_hit(reg_idx_t dst, reg_idx_t src, logic en);
    return en && (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle.
// master: pipeline side (drives stage fields, receives controls).
// slave:  hazard unit side.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  reg_idx_t   RsD;
  reg_idx_t   RtD;
  reg_idx_t   RsE;
  reg_idx_t   RtE;
  reg_idx_t   WriteRegE;
  logic       RegWriteE;
  logic       MemtoRegE;
  logic       BranchD;

  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       ForwardAD;
  logic       ForwardBD;
  logic       StallF;
  logic       StallD;
  logic       FlushE;
  cnt_t       stall_cnt;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, BranchD,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, stall_cnt
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, RegWriteE, MemtoRegE, BranchD,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, FlushE, stall_cnt
  );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Single execute-operand forward select; memory-stage producer wins over
// writeback-stage producer.
module hazard_fwd_sel
  import hazard_unit_pkg::*;
(
  input  reg_idx_t src_i,
  input  reg_idx_t WriteRegM_i,
  input  logic     RegWriteM_i,
  input  reg_idx_t WriteRegW_i,
  input  logic     RegWriteW_i,
  output fwd_sel_e sel_o
);

  // Priority select: M, then W, else register file
  always_comb begin
    sel_o = FWD_REG;
    if (reg_hit(WriteRegM_i, src_i, RegWriteM_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_hit(WriteRegW_i, src_i, RegWriteW_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall detection and a
// saturating stall-cycle counter.
// Build option: HAZARD_BRANCH_FWD_EN adds decode-stage branch forwarding and
// branch stalls; without it ForwardAD/ForwardBD are 0 and BranchD is unused.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);

  reg_idx_t wreg_m_q, wreg_m_d;
  logic     regwrite_m_q, regwrite_m_d;
  logic     memtoreg_m_q, memtoreg_m_d;
  reg_idx_t wreg_w_q, wreg_w_d;
  logic     regwrite_w_q, regwrite_w_d;
  cnt_t     cnt_q, cnt_d;

  logic     lwstall;
  logic     branchstall;
  logic     stall;
  logic     fwd_ad;
  logic     fwd_bd;
  fwd_sel_e fae_sel;
  fwd_sel_e fbe_sel;

  hazard_fwd_sel u_fwd_a (
    .src_i       (hz.RsE),
    .WriteRegM_i (wreg_m_q),
    .RegWriteM_i (regwrite_m_q),
    .WriteRegW_i (wreg_w_q),
    .RegWriteW_i (regwrite_w_q),
    .sel_o       (fae_sel)
  );

  hazard_fwd_sel u_fwd_b (
    .src_i       (hz.RtE),
    .WriteRegM_i (wreg_m_q),
    .RegWriteM_i (regwrite_m_q),
    .WriteRegW_i (wreg_w_q),
    .RegWriteW_i (regwrite_w_q),
    .sel_o       (fbe_sel)
  );

  // Load-use hazard: a load in E feeds a source read in D
  always_comb begin
    lwstall = hz.MemtoRegE &&
              (reg_hit(hz.WriteRegE, hz.RsD, hz.RegWriteE) ||
               reg_hit(hz.WriteRegE, hz.RtD, hz.RegWriteE));
  end

`ifdef HAZARD_BRANCH_FWD_EN
  // Branch compare in D: forward ALUOutM, stall on an E result or a pending load in M
  always_comb begin
    fwd_ad      = reg_hit(wreg_m_q, hz.RsD, regwrite_m_q);
    fwd_bd      = reg_hit(wreg_m_q, hz.RtD, regwrite_m_q);
    branchstall = hz.BranchD &&
                  (reg_hit(hz.WriteRegE, hz.RsD, hz.RegWriteE) ||
                   reg_hit(hz.WriteRegE, hz.RtD, hz.RegWriteE) ||
                   reg_hit(wreg_m_q, hz.RsD, memtoreg_m_q)     ||
                   reg_hit(wreg_m_q, hz.RtD, memtoreg_m_q));
  end
`else
  // Branch support compiled out
  always_comb begin
    fwd_ad      = 1'b0;
    fwd_bd      = 1'b0;
    branchstall = 1'b0;
  end
`endif

  // Reset kills any stall in the same cycle so it is neither driven nor counted
  always_comb begin
    stall = (lwstall || branchstall) && !rst;
  end

  // Next state: shadows advance every cycle, a flush bubbles the M controls
  always_comb begin
    wreg_m_d     = hz.WriteRegE;
    regwrite_m_d = hz.RegWriteE && !stall;
    memtoreg_m_d = hz.MemtoRegE && !stall;
    wreg_w_d     = wreg_m_q;
    regwrite_w_d = regwrite_m_q;
    cnt_d        = cnt_q;
    if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Shadow pipeline and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wreg_m_q     <= '0;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      wreg_w_q     <= '0;
      regwrite_w_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      wreg_m_q     <= wreg_m_d;
      regwrite_m_q <= regwrite_m_d;
      memtoreg_m_q <= memtoreg_m_d;
      wreg_w_q     <= wreg_w_d;
      regwrite_w_q <= regwrite_w_d;
      cnt_q        <= cnt_d;
    end
  end

  // Output drive, forced to 0 while reset is held
  always_comb begin
    hz.ForwardAE = FWD_REG;
    hz.ForwardBE = FWD_REG;
    hz.ForwardAD = 1'b0;
    hz.ForwardBD = 1'b0;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.stall_cnt = '0;
    if (!rst) begin
      hz.ForwardAE = fae_sel;
      hz.ForwardBE = fbe_sel;
      hz.ForwardAD = fwd_ad;
      hz.ForwardBD = fwd_bd;
      hz.StallF    = stall;
      hz.StallD    = stall;
      hz.FlushE    = stall;
      hz.stall_cnt = cnt_q;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios, randomized
// traffic against a history-based reference model, and counter saturation.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_unit_if hz ();

  hazard_unit dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // Reference model: the last two instructions that left E.
  // hist[0] is one cycle old (M), hist[1] two cycles old (W).
  typedef struct {
    int unsigned rd;
    bit          we;
    bit          ld;
  } wr_t;

  wr_t         hist[$];
  int unsigned model_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void hist_clear();
    wr_t z;
    z.rd = 0; z.we = 0; z.ld = 0;
    hist = '{z, z};
  endfunction

  function automatic int unsigned exp_fwd_e(int unsigned src);
    if (src == 0) return 0;
    for (int unsigned age = 0; age < 2; age++)
      if (hist[age].we && hist[age].rd == src) return (age == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit dsrc_is(int unsigned r);
    return (r != 0) && (r == int'(hz.RsD) || r == int'(hz.RtD));
  endfunction

  function automatic bit exp_stall();
    bit lw;
    bit br;
    lw = hz.MemtoRegE && hz.RegWriteE && dsrc_is(hz.WriteRegE);
    br = 1'b0;
`ifdef HAZARD_BRANCH_FWD_EN
    br = hz.BranchD && ((hz.RegWriteE && dsrc_is(hz.WriteRegE)) ||
                        (hist[0].ld && dsrc_is(hist[0].rd)));
`endif
    return !rst && (lw || br);
  endfunction

  function automatic bit exp_fwd_d(int unsigned src);
`ifdef HAZARD_BRANCH_FWD_EN
    return (src != 0) && hist[0].we && hist[0].rd == src;
`else
    return 1'b0 && (src != 0);
`endif
  endfunction

  task automatic compare_all(input string tag);
    bit st;
    st = exp_stall();
    check({tag, "/FAE"},  hz.ForwardAE, rst ? 0 : exp_fwd_e(hz.RsE));
    check({tag, "/FBE"},  hz.ForwardBE, rst ? 0 : exp_fwd_e(hz.RtE));
    check({tag, "/FAD"},  hz.ForwardAD, rst ? 0 : exp_fwd_d(hz.RsD));
    check({tag, "/FBD"},  hz.ForwardBD, rst ? 0 : exp_fwd_d(hz.RtD));
    check({tag, "/STF"},  hz.StallF, st);
    check({tag, "/STD"},  hz.StallD, st);
    check({tag, "/FLE"},  hz.FlushE, st);
    check({tag, "/CNT"},  hz.stall_cnt, rst ? 0 : model_cnt);
  endtask

  // Advance the model across one rising edge
  task automatic tick();
    bit  st;
    wr_t e;
    st   = exp_stall();
    e.rd = hz.WriteRegE;
    e.we = hz.RegWriteE && !st;
    e.ld = hz.MemtoRegE && !st;
    @(posedge clk);
    if (rst) begin
      hist_clear();
      model_cnt = 0;
    end else begin
      hist.push_front(e);
      void'(hist.pop_back());
      if (st && model_cnt < 65535) model_cnt++;
    end
    #1;
  endtask

  task automatic drive(input int unsigned rsd, input int unsigned rtd,
                       input int unsigned rse, input int unsigned rte,
                       input int unsigned wre, input bit rwe, input bit m2r,
                       input bit br);
    hz.RsD       = reg_idx_t'(rsd);
    hz.RtD       = reg_idx_t'(rtd);
    hz.RsE       = reg_idx_t'(rse);
    hz.RtE       = reg_idx_t'(rte);
    hz.WriteRegE = reg_idx_t'(wre);
    hz.RegWriteE = rwe;
    hz.MemtoRegE = m2r;
    hz.BranchD   = br;
  endtask

  task automatic step(input string tag, input bit do_check);
    #1;
    if (do_check) compare_all(tag);
    tick();
  endtask

  initial begin
    hist_clear();
    model_cnt = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    // Reset state with stall-inducing inputs: everything must stay 0
    drive(9, 9, 9, 9, 9, 1, 1, 1);
    step("rst", 1);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_cnt", hz.stall_cnt, 0);
    check("rst_fae", hz.ForwardAE, 0);
    step("idle", 1);

    // E writes r8; one cycle later M forwards, two cycles later W forwards
    drive(0, 0, 0, 0, 8, 1, 0, 0);
    step("r8_prod", 1);
    drive(0, 0, 8, 0, 0, 0, 0, 0);
    #1; check("r8_mem", hz.ForwardAE, 2'b10);
    step("r8_mem", 1);
    drive(0, 0, 8, 0, 0, 0, 0, 0);
    #1; check("r8_wb", hz.ForwardAE, 2'b01);
    step("r8_wb", 1);

    // r5 in both M and W: M wins
    drive(0, 0, 0, 0, 5, 1, 0, 0);
    step("r5_a", 1);
    drive(0, 0, 0, 0, 5, 1, 0, 0);
    step("r5_b", 1);
    drive(0, 0, 0, 5, 0, 0, 0, 0);
    #1; check("r5_prio", hz.ForwardBE, 2'b10);
    step("r5_prio", 1);

    // Load-use on r9: one stall cycle, then bubble in M
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("pre_lw", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("pre_lw2", 1);
    drive(9, 0, 0, 0, 9, 1, 1, 0);
    #1;
    check("lw_stf", hz.StallF, 1);
    check("lw_std", hz.StallD, 1);
    check("lw_fle", hz.FlushE, 1);
    check("lw_cnt0", hz.stall_cnt, 0);
    step("lw", 1);
    drive(0, 0, 9, 0, 0, 0, 0, 0);
    #1;
    check("lw_cnt1", hz.stall_cnt, 1);
    check("lw_bubble", hz.ForwardAE, 2'b00);
    check("lw_rwm", dut.regwrite_m_q, 0);
    check("lw_end", hz.StallD, 0);
    step("lw_after", 1);

    // Register 0 never stalls or forwards
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    #1; check("r0_stall", hz.StallD, 0);
    step("r0_a", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1; check("r0_fwd", hz.ForwardAE, 2'b00);
    step("r0_b", 1);

`ifdef HAZARD_BRANCH_FWD_EN
    // Branch on r3 while E writes r3: stall
    drive(0, 3, 0, 0, 3, 1, 0, 1);
    #1; check("br_stall", hz.StallD, 1);
    step("br_stall", 1);
    drive(0, 3, 0, 0, 0, 0, 0, 1);
    #1; check("br_release", hz.StallD, 0);
    step("br_release", 1);
    // Producer reaches M without a stall: comparator forwarding
    drive(0, 0, 0, 0, 3, 1, 0, 0);
    step("brf_prod", 1);
    drive(0, 3, 0, 0, 0, 0, 0, 1);
    #1;
    check("brf_fbd", hz.ForwardBD, 1);
    check("brf_nostall", hz.StallD, 0);
    step("brf", 1);
`endif

    // Randomized traffic over a small register range to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(63) == 0);
      drive($urandom_range(7), $urandom_range(7), $urandom_range(7),
            $urandom_range(7), $urandom_range(7), $urandom_range(1),
            $urandom_range(1), $urandom_range(1));
      step("rand", 1);
    end

    // Saturation: hold a load-use stall until the counter pegs
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_rst", 1);
    rst = 1'b0;
    drive(9, 0, 0, 0, 9, 1, 1, 0);
    for (int i = 0; i < 65535; i++) step("sat_fill", 0);
    #1; check("sat_full", hz.stall_cnt, 16'hFFFF);
    step("sat_hold", 1);
    #1;
    check("sat_nowrap", hz.stall_cnt, 16'hFFFF);
    check("sat_stall", hz.StallD, 1);

    // Reset mid-stall: stall drops immediately and the cycle is not counted
    rst = 1'b1;
    #1;
    check("rst_mid_std", hz.StallD, 0);
    check("rst_mid_cnt", hz.stall_cnt, 0);
    step("rst_mid", 1);
    rst = 1'b0;
    #1; check("rst_mid_clr", hz.stall_cnt, 0);
    step("post_rst", 1);
    #1; check("post_rst_cnt", hz.stall_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
